// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port integer register file: default widths,
// sweep/run state encoding and the hard-wired zero register index.
package regfile_mp_pkg;

    localparam int MXLEN       = 32;
    localparam int DEF_XLEN    = MXLEN;
    localparam int DEF_REG_NUM = 32;
    localparam int DEF_AW      = 5;
    localparam int ZERO_REG    = 0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_mp_rdport.sv
// One combinational read port: storage/pending lookup plus the optional
// same-cycle write-data forward.
module regfile_rdport
    import regfile_mp_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int REG_NUM = DEF_REG_NUM,
    parameter int AW      = DEF_AW,
    parameter int BYPASS  = 1
) (
    input  logic                    running,
    input  logic [AW-1:0]           r_addr,
    input  logic [REG_NUM*XLEN-1:0] rf_flat,
    input  logic [REG_NUM-1:0]      pend,
    input  logic                    wr_qual,
    input  logic [AW-1:0]           w_addr,
    input  logic [XLEN-1:0]         w_data,
    input  logic                    iss_qual,
    input  logic [AW-1:0]           iss_addr,
    output logic [XLEN-1:0]         r_data,
    output logic                    r_pend
);

    logic [XLEN-1:0] words [REG_NUM];

    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            words[i] = rf_flat[i*XLEN +: XLEN];
        end
    end

    // wr_qual already excludes x0, so a forward can never expose a nonzero x0.
    always_comb begin
        r_data = '0;
        r_pend = 1'b0;
        if (running) begin
            if ((BYPASS != 0) && wr_qual && (w_addr == r_addr)) begin
                r_data = w_data;
                r_pend = iss_qual && (iss_addr == r_addr);
            end else begin
                r_data = words[r_addr];
                r_pend = pend[r_addr];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with post-reset clearing sweep, per-register
// pending scoreboard and NRD combinational read ports.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN           = DEF_XLEN,
    parameter int REG_NUM        = DEF_REG_NUM,
    parameter int AW             = DEF_AW,
    parameter int NRD            = 2,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                exception,
    input  logic [NRD*AW-1:0]   r_addr,
    output logic [NRD*XLEN-1:0] r_data,
    output logic [NRD-1:0]      r_pend,
    input  logic                reg_write,
    input  logic [AW-1:0]       w_addr,
    input  logic [XLEN-1:0]     w_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_addr,
    output logic                ready,
    output logic                dbg_state
);

    state_t                  state;
    logic [AW-1:0]           clr_cnt;
    logic                    ready_q;
    logic [REG_NUM-1:0]      pend;
    logic [XLEN-1:0]         regs [REG_NUM];
    logic [REG_NUM*XLEN-1:0] rf_flat;
    logic                    running;
    logic                    wr_qual;
    logic                    iss_qual;

    // ready is a level: writes and issues are only honoured while it is high.
    assign running   = (state == ST_RUN);
    assign ready     = ready_q;
    assign dbg_state = state;

    assign wr_qual  = running && !RST && reg_write && !exception && (w_addr != AW'(ZERO_REG));
    assign iss_qual = running && !RST && iss_valid && !exception && (iss_addr != AW'(ZERO_REG));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt <= AW'(1);
            ready_q <= (CLEAR_ON_RESET == 0);
            pend    <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == AW'(REG_NUM - 1)) begin
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (exception) begin
                        pend <= '0;
                    end else begin
                        // Issue after write so a new producer keeps the bit set.
                        if (wr_qual) pend[w_addr] <= 1'b0;
                        if (iss_qual) pend[iss_addr] <= 1'b1;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && (state == ST_CLEAR)) begin
            regs[clr_cnt] <= '0;
        end else if (wr_qual) begin
            regs[w_addr] <= w_data;
        end
    end

    // x0 is never stored; it is presented as constant zero to every port.
    always_comb begin
        rf_flat = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            rf_flat[i*XLEN +: XLEN] = regs[i];
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        regfile_rdport #(
            .XLEN    (XLEN),
            .REG_NUM (REG_NUM),
            .AW      (AW),
            .BYPASS  (BYPASS)
        ) u_rdport (
            .running  (running),
            .r_addr   (r_addr[p*AW +: AW]),
            .rf_flat  (rf_flat),
            .pend     (pend),
            .wr_qual  (wr_qual),
            .w_addr   (w_addr),
            .w_data   (w_data),
            .iss_qual (iss_qual),
            .iss_addr (iss_addr),
            .r_data   (r_data[p*XLEN +: XLEN]),
            .r_pend   (r_pend[p])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypassing and a non-bypassing instance share stimulus
// and are compared every cycle against an array-based reference model.
module tb_regfile_mp;
    import regfile_mp_pkg::*;

    localparam int XLEN    = 32;
    localparam int REG_NUM = 32;
    localparam int AW      = 5;
    localparam int NRD     = 2;
    localparam int CW      = 2 + 2*NRD + 2*NRD*XLEN;

    logic                CLK = 1'b0;
    logic                RST;
    logic                exception;
    logic [NRD*AW-1:0]   r_addr;
    logic                reg_write;
    logic [AW-1:0]       w_addr;
    logic [XLEN-1:0]     w_data;
    logic                iss_valid;
    logic [AW-1:0]       iss_addr;

    logic [NRD*XLEN-1:0] r_data_b, r_data_n;
    logic [NRD-1:0]      r_pend_b, r_pend_n;
    logic                ready_b, ready_n;
    logic                dbg_b, dbg_n;

    // Clock / reset block: reset itself is driven through the step task.
    always #5 CLK = ~CLK;

    regfile_mp #(.BYPASS(1)) u_byp (
        .CLK(CLK), .RST(RST), .exception(exception), .r_addr(r_addr),
        .r_data(r_data_b), .r_pend(r_pend_b), .reg_write(reg_write),
        .w_addr(w_addr), .w_data(w_data), .iss_valid(iss_valid),
        .iss_addr(iss_addr), .ready(ready_b), .dbg_state(dbg_b)
    );

    regfile_mp #(.BYPASS(0)) u_nob (
        .CLK(CLK), .RST(RST), .exception(exception), .r_addr(r_addr),
        .r_data(r_data_n), .r_pend(r_pend_n), .reg_write(reg_write),
        .w_addr(w_addr), .w_data(w_data), .iss_valid(iss_valid),
        .iss_addr(iss_addr), .ready(ready_n), .dbg_state(dbg_n)
    );

    // Reference model: architectural contents, pending flags, cycles since reset.
    logic [XLEN-1:0] m_mem [REG_NUM];
    bit              m_pend [REG_NUM];
    int              m_since = 0;
    bit              m_known = 0;

    logic [CW-1:0] exp_q[$];
    string         name_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic step(input bit rst, input bit rw, input int wa, input logic [XLEN-1:0] wd,
                        input bit iv, input int ia, input bit exc,
                        input int ra0, input int ra1, input string name);
        logic [CW-1:0]   e;
        bit              run, wq, iq;
        int              ra [NRD];
        logic [XLEN-1:0] db [NRD];
        logic [XLEN-1:0] dn [NRD];
        bit              pb [NRD];
        bit              pn [NRD];
        @(posedge CLK);
        #1;
        RST       = rst;
        reg_write = rw;
        w_addr    = AW'(wa);
        w_data    = wd;
        iss_valid = iv;
        iss_addr  = AW'(ia);
        exception = exc;
        r_addr    = {AW'(ra1), AW'(ra0)};
        ra[0] = ra0;
        ra[1] = ra1;
        run = (m_since >= REG_NUM - 1);
        wq  = run && !rst && rw && !exc && (wa != 0);
        iq  = run && !rst && iv && !exc && (ia != 0);
        for (int p = 0; p < NRD; p++) begin
            db[p] = '0; dn[p] = '0; pb[p] = 0; pn[p] = 0;
            if (run && ra[p] != 0) begin
                dn[p] = m_mem[ra[p]];
                pn[p] = m_pend[ra[p]];
                db[p] = dn[p];
                pb[p] = pn[p];
                if (wq && wa == ra[p]) begin
                    db[p] = wd;
                    pb[p] = iq && (ia == ra[p]);
                end
            end
        end
        e = {run, run, pb[1], pb[0], pn[1], pn[0], db[1], db[0], dn[1], dn[0]};
        if (m_known) begin
            exp_q.push_back(e);
            name_q.push_back(name);
        end
        // Advance the model across the coming clock edge.
        if (rst) begin
            for (int r = 0; r < REG_NUM; r++) begin
                m_mem[r]  = '0;
                m_pend[r] = 0;
            end
            m_since = 0;
            m_known = 1;
        end else begin
            if (run) begin
                if (exc) begin
                    for (int r = 0; r < REG_NUM; r++) m_pend[r] = 0;
                end else begin
                    if (wq) begin
                        m_mem[wa]  = wd;
                        m_pend[wa] = 0;
                    end
                    if (iq) m_pend[ia] = 1;
                end
            end
            if (m_since < REG_NUM - 1) m_since++;
        end
    endtask

    task automatic idle(input int ra0, input int ra1, input string name);
        step(0, 0, 0, '0, 0, 0, 0, ra0, ra1, name);
    endtask

    task automatic rand_traffic(input string name);
        int wa;
        wa = $urandom_range(0, REG_NUM - 1);
        step(0, 1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 1)),
             $urandom_range(0, REG_NUM - 1), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 1) != 0) ? wa : $urandom_range(0, REG_NUM - 1),
             $urandom_range(0, REG_NUM - 1), name);
    endtask

    // Scoreboard monitor: samples mid-cycle, away from the active edge.
    always @(negedge CLK) begin
        logic [CW-1:0] got, e;
        string nm;
        if (exp_q.size() != 0) begin
            got = {ready_b, ready_n, r_pend_b, r_pend_n, r_data_b, r_data_n};
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            n_checks++;
            if (got === e) n_pass++;
            else $display("FAIL %s: got %h expected %h", nm, got, e);
        end
    end

    initial begin
        RST = 1'b1; exception = 1'b0; r_addr = '0; reg_write = 1'b0;
        w_addr = '0; w_data = '0; iss_valid = 1'b0; iss_addr = '0;

        step(1, 0, 0, '0, 0, 0, 0, 0, 0, "reset");
        step(1, 0, 0, '0, 0, 0, 0, 0, 0, "reset");
        repeat (32) idle($urandom_range(0, REG_NUM - 1), $urandom_range(0, REG_NUM - 1), "sweep_ready");
        for (int a = 0; a < REG_NUM; a += 2) idle(a, a + 1, "cleared");

        step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 2, "wr_x5");
        idle(5, 0, "rd_x5");
        step(0, 1, 0, 32'h00001234, 0, 0, 0, 5, 0, "wr_x0");
        idle(5, 0, "rd_x0");

        step(0, 1, 7, 32'hA5A5A5A5, 0, 0, 0, 7, 5, "bypass");
        idle(7, 0, "bypass_next");

        step(0, 0, 0, '0, 1, 4, 0, 4, 9, "iss_x4");
        step(0, 0, 0, '0, 1, 9, 0, 4, 9, "iss_x9");
        step(0, 1, 3, 32'hFFFF0000, 1, 6, 1, 4, 9, "exc");
        idle(4, 9, "exc_flush");
        idle(3, 6, "exc_nowrite");

        step(0, 0, 0, '0, 1, 10, 0, 10, 0, "iss_x10");
        idle(10, 0, "pend_x10");
        step(0, 1, 10, 32'h0BADF00D, 0, 0, 0, 10, 0, "wr_x10");
        idle(10, 0, "clr_x10");
        step(0, 1, 10, 32'h13579BDF, 1, 10, 0, 10, 10, "iss_wr_x10");
        idle(10, 0, "set_wins");

        repeat (400) rand_traffic("random");

        step(1, 0, 0, '0, 0, 0, 0, 0, 0, "rst2");
        repeat (15) rand_traffic("sweep_ignore");
        step(1, 0, 0, '0, 0, 0, 0, 0, 0, "rst_mid");
        repeat (31) rand_traffic("sweep_ignore2");
        for (int a = 0; a < REG_NUM; a += 2) idle(a, a + 1, "post_sweep");
        repeat (100) rand_traffic("random2");

        @(negedge CLK);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
